// File: rtl/pipe_control.sv
// RV32I control unit: decode in D, control word shifts D->E->M->WB; redirect from M one cycle after E.
// Latency: E selects 1 cycle after decode, pc_SEL 1 cycle after E; no backpressure, always advances.
module pipe_control #(
    parameter int   XLEN            = 32,
    parameter logic RESET_VEC_VALID = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] Instr,
    input  logic            alu_eq,
    input  logic            alu_lt,
    input  logic            alu_ltu,
    output logic [2:0]      imm_SEL,
    output logic            rs1_SEL,
    output logic            rs2_SEL,
    output logic [3:0]      ALU_SEL,
    output logic [1:0]      pc_SEL,
    output logic            mem_WE,
    output logic [1:0]      reg_SEL,
    output logic            reg_WE,
    output logic            flush,
    output logic            illegal
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef struct packed {
        logic       rs1_sel;
        logic       rs2_sel;
        logic [3:0] alu_sel;
        logic       is_br;
        logic       is_jmp;
        logic       pc_imm;
        logic [2:0] funct3;
        logic       mem_we;
        logic       reg_we;
        logic [1:0] reg_sel;
    } ctrl_t;

    logic [XLEN-1:0] instr_q, instr_d;
    logic            v_d_q, v_d_d, v_e_q, v_e_d, v_m_q, v_m_d, v_wb_q, v_wb_d;
    ctrl_t           ctrl_e_q, ctrl_e_d;
    logic            mem_we_m_q, mem_we_m_d, reg_we_m_q, reg_we_m_d;
    logic [1:0]      reg_sel_m_q, reg_sel_m_d;
    logic            reg_we_wb_q, reg_we_wb_d;
    logic [1:0]      reg_sel_wb_q, reg_sel_wb_d;
    logic            redir_m_q, redir_m_d, pc_imm_m_q, pc_imm_m_d;
    logic            illegal_q, illegal_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic [4:0] rd;
    ctrl_t      dec;
    logic [2:0] dec_imm;
    logic       dec_illegal;
    logic [3:0] alu_base;
    logic       br_cond;
    logic       redirect;
    logic       unused_bits;

    assign opcode      = instr_q[6:0];
    assign rd          = instr_q[11:7];
    assign funct3      = instr_q[14:12];
    assign f7b5        = instr_q[30];
    assign unused_bits = ^{instr_q[XLEN-1:31], instr_q[29:15]};

    always_comb begin
        alu_base = ALU_ADD;
        case (funct3)
            3'b000:  alu_base = ALU_ADD;
            3'b001:  alu_base = ALU_SLL;
            3'b010:  alu_base = ALU_SLT;
            3'b011:  alu_base = ALU_SLTU;
            3'b100:  alu_base = ALU_XOR;
            3'b101:  alu_base = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_base = ALU_OR;
            default: alu_base = ALU_AND;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.funct3  = funct3;
        dec_imm     = 3'd0;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.alu_sel = (funct3 == 3'b000 && f7b5) ? ALU_SUB : alu_base;
                dec.reg_sel = 2'd1;
                dec.reg_we  = 1'b1;
            end
            OPC_OP_IMM: begin
                // funct7[5] is immediate data for ADDI, so only the shift decode honours it
                dec.alu_sel = alu_base;
                dec.rs2_sel = 1'b1;
                dec.reg_sel = 2'd1;
                dec.reg_we  = 1'b1;
            end
            OPC_LOAD: begin
                dec.rs2_sel = 1'b1;
                dec.reg_we  = 1'b1;
            end
            OPC_STORE: begin
                dec.rs2_sel = 1'b1;
                dec.mem_we  = 1'b1;
                dec_imm     = 3'd1;
            end
            OPC_LUI: begin
                dec.reg_sel = 2'd2;
                dec.reg_we  = 1'b1;
                dec_imm     = 3'd3;
            end
            OPC_AUIPC: begin
                dec.rs1_sel = 1'b1;
                dec.rs2_sel = 1'b1;
                dec.reg_sel = 2'd1;
                dec.reg_we  = 1'b1;
                dec_imm     = 3'd3;
            end
            OPC_JAL: begin
                dec.is_jmp  = 1'b1;
                dec.pc_imm  = 1'b1;
                dec.reg_sel = 2'd3;
                dec.reg_we  = 1'b1;
                dec_imm     = 3'd4;
            end
            OPC_JALR: begin
                dec.rs2_sel = 1'b1;
                dec.is_jmp  = 1'b1;
                dec.reg_sel = 2'd3;
                dec.reg_we  = 1'b1;
            end
            OPC_BRANCH: begin
                dec.alu_sel = ALU_SUB;
                dec.is_br   = 1'b1;
                dec.pc_imm  = 1'b1;
                dec_imm     = 3'd2;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (rd == 5'd0) begin
            dec.reg_we = 1'b0;
        end
    end

    always_comb begin
        br_cond = 1'b0;
        case (ctrl_e_q.funct3)
            3'b000:  br_cond = alu_eq;
            3'b001:  br_cond = ~alu_eq;
            3'b100:  br_cond = alu_lt;
            3'b101:  br_cond = ~alu_lt;
            3'b110:  br_cond = alu_ltu;
            3'b111:  br_cond = ~alu_ltu;
            default: br_cond = 1'b0;
        endcase
        // a slot already marked wrong-path by the redirect in M must not redirect again
        redirect = v_e_q & ~redir_m_q & (ctrl_e_q.is_jmp | (ctrl_e_q.is_br & br_cond));
    end

    always_comb begin
        instr_d      = Instr;
        v_d_d        = ~redir_m_q;
        v_e_d        = v_d_q & ~redir_m_q;
        v_m_d        = v_e_q & ~redir_m_q;
        v_wb_d       = v_m_q;
        ctrl_e_d     = v_e_d ? dec : ctrl_e_q;
        mem_we_m_d   = v_e_q ? ctrl_e_q.mem_we  : mem_we_m_q;
        reg_we_m_d   = v_e_q ? ctrl_e_q.reg_we  : reg_we_m_q;
        reg_sel_m_d  = v_e_q ? ctrl_e_q.reg_sel : reg_sel_m_q;
        reg_we_wb_d  = v_m_q ? reg_we_m_q  : reg_we_wb_q;
        reg_sel_wb_d = v_m_q ? reg_sel_m_q : reg_sel_wb_q;
        redir_m_d    = redirect;
        pc_imm_m_d   = redirect & ctrl_e_q.pc_imm;
        illegal_d    = illegal_q | (v_d_q & dec_illegal);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q      <= '0;
            v_d_q        <= RESET_VEC_VALID;
            v_e_q        <= 1'b0;
            v_m_q        <= 1'b0;
            v_wb_q       <= 1'b0;
            ctrl_e_q     <= '0;
            mem_we_m_q   <= 1'b0;
            reg_we_m_q   <= 1'b0;
            reg_sel_m_q  <= 2'd0;
            reg_we_wb_q  <= 1'b0;
            reg_sel_wb_q <= 2'd0;
            redir_m_q    <= 1'b0;
            pc_imm_m_q   <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            instr_q      <= instr_d;
            v_d_q        <= v_d_d;
            v_e_q        <= v_e_d;
            v_m_q        <= v_m_d;
            v_wb_q       <= v_wb_d;
            ctrl_e_q     <= ctrl_e_d;
            mem_we_m_q   <= mem_we_m_d;
            reg_we_m_q   <= reg_we_m_d;
            reg_sel_m_q  <= reg_sel_m_d;
            reg_we_wb_q  <= reg_we_wb_d;
            reg_sel_wb_q <= reg_sel_wb_d;
            redir_m_q    <= redir_m_d;
            pc_imm_m_q   <= pc_imm_m_d;
            illegal_q    <= illegal_d;
        end
    end

    assign imm_SEL = dec_imm;
    assign rs1_SEL = ctrl_e_q.rs1_sel;
    assign rs2_SEL = ctrl_e_q.rs2_sel;
    assign ALU_SEL = ctrl_e_q.alu_sel;
    assign pc_SEL  = {pc_imm_m_q, redir_m_q};
    assign flush   = redir_m_q;
    assign mem_WE  = mem_we_m_q & v_m_q;
    assign reg_SEL = reg_sel_wb_q;
    assign reg_WE  = reg_we_wb_q & v_wb_q;
    assign illegal = illegal_q;
endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: instruction-level pipeline model plus hand-computed spot checks.
module tb_pipe_control;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] ADD   = 32'h003100B3;
    localparam logic [31:0] SUB   = 32'h40310133;
    localparam logic [31:0] SRAI  = 32'h4032D293;
    localparam logic [31:0] SW    = 32'h0020A023;
    localparam logic [31:0] BEQ   = 32'h00208463;
    localparam logic [31:0] JALR  = 32'h000100E7;
    localparam logic [31:0] ADDI0 = 32'h00100013;
    localparam logic [31:0] ILL   = 32'h0000007F;
    localparam int          N     = 33;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instr = NOP;
    logic        alu_eq = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
    logic [2:0]  imm_SEL;
    logic        rs1_SEL, rs2_SEL;
    logic [3:0]  ALU_SEL;
    logic [1:0]  pc_SEL;
    logic        mem_WE;
    logic [1:0]  reg_SEL;
    logic        reg_WE, flush, illegal;

    int checks = 0;
    int errors = 0;

    pipe_control #(.XLEN(32), .RESET_VEC_VALID(1'b0)) dut (
        .clk(clk), .reset(reset), .Instr(Instr),
        .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .imm_SEL(imm_SEL), .rs1_SEL(rs1_SEL), .rs2_SEL(rs2_SEL), .ALU_SEL(ALU_SEL),
        .pc_SEL(pc_SEL), .mem_WE(mem_WE), .reg_SEL(reg_SEL), .reg_WE(reg_WE),
        .flush(flush), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level reference ----------------
    typedef struct packed {
        logic [2:0] imm;
        logic       rs1;
        logic       rs2;
        logic [3:0] alu;
        logic       mwe;
        logic       rwe;
        logic [1:0] rsel;
        logic       jmp;
        logic       br;
        logic       pcimm;
        logic       ill;
    } dec_t;

    function automatic dec_t dec(input logic [31:0] w);
        dec_t       d;
        logic [2:0] f3;
        logic [3:0] base;
        d  = '0;
        f3 = w[14:12];
        case (f3)
            3'd0: base = 4'd0;
            3'd1: base = 4'd2;
            3'd2: base = 4'd3;
            3'd3: base = 4'd4;
            3'd4: base = 4'd5;
            3'd5: base = w[30] ? 4'd7 : 4'd6;
            3'd6: base = 4'd8;
            default: base = 4'd9;
        endcase
        case (w[6:0])
            7'h33: begin d.alu = (f3 == 3'd0 && w[30]) ? 4'd1 : base; d.rsel = 2'd1; d.rwe = 1'b1; end
            7'h13: begin d.alu = base; d.rs2 = 1'b1; d.rsel = 2'd1; d.rwe = 1'b1; end
            7'h03: begin d.rs2 = 1'b1; d.rwe = 1'b1; end
            7'h23: begin d.imm = 3'd1; d.rs2 = 1'b1; d.mwe = 1'b1; end
            7'h37: begin d.imm = 3'd3; d.rsel = 2'd2; d.rwe = 1'b1; end
            7'h17: begin d.imm = 3'd3; d.rs1 = 1'b1; d.rs2 = 1'b1; d.rsel = 2'd1; d.rwe = 1'b1; end
            7'h6F: begin d.imm = 3'd4; d.jmp = 1'b1; d.pcimm = 1'b1; d.rsel = 2'd3; d.rwe = 1'b1; end
            7'h67: begin d.rs2 = 1'b1; d.jmp = 1'b1; d.rsel = 2'd3; d.rwe = 1'b1; end
            7'h63: begin d.imm = 3'd2; d.alu = 4'd1; d.br = 1'b1; d.pcimm = 1'b1; end
            default: d.ill = 1'b1;
        endcase
        if (w[11:7] == 5'd0) d.rwe = 1'b0;
        return d;
    endfunction

    function automatic logic takes(input logic [31:0] w, input logic eq, input logic lt, input logic ltu);
        dec_t d;
        d = dec(w);
        if (d.jmp) return 1'b1;
        if (!d.br) return 1'b0;
        case (w[14:12])
            3'd0: return eq;
            3'd1: return !eq;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction words per stage, plus the last word that was valid in E and in WB (held selects).
    logic [31:0] m_id = '0, m_ie = '0, m_im = '0, m_iw = '0, m_he = '0, m_hw = '0;
    logic        m_vd = 1'b0, m_ve = 1'b0, m_vm = 1'b0, m_vw = 1'b0;
    logic        m_redir = 1'b0, m_pc1 = 1'b0, m_ill = 1'b0;
    logic        m_tk;
    dec_t        w_d, w_e, w_m, w_w, w_he, w_hw;

    assign w_d  = dec(m_id);
    assign w_e  = dec(m_ie);
    assign w_m  = dec(m_im);
    assign w_w  = dec(m_iw);
    assign w_he = dec(m_he);
    assign w_hw = dec(m_hw);
    assign m_tk = m_ve && !m_redir && takes(m_ie, alu_eq, alu_lt, alu_ltu);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_id <= '0; m_ie <= '0; m_im <= '0; m_iw <= '0; m_he <= '0; m_hw <= '0;
            m_vd <= 1'b0; m_ve <= 1'b0; m_vm <= 1'b0; m_vw <= 1'b0;
            m_redir <= 1'b0; m_pc1 <= 1'b0; m_ill <= 1'b0;
        end else begin
            m_id    <= Instr;
            m_vd    <= !m_redir;
            m_ie    <= m_id;
            m_ve    <= m_vd && !m_redir;
            m_im    <= m_ie;
            m_vm    <= m_ve && !m_redir;
            m_iw    <= m_im;
            m_vw    <= m_vm;
            m_he    <= (m_vd && !m_redir) ? m_id : m_he;
            m_hw    <= m_vm ? m_im : m_hw;
            m_redir <= m_tk;
            m_pc1   <= m_tk && w_e.pcimm;
            m_ill   <= m_ill || (m_vd && w_d.ill);
        end
    end

    always @(negedge clk) begin
        chk("imm_SEL", {29'd0, imm_SEL}, {29'd0, w_d.imm});
        chk("rs1_SEL", {31'd0, rs1_SEL}, {31'd0, w_he.rs1});
        chk("rs2_SEL", {31'd0, rs2_SEL}, {31'd0, w_he.rs2});
        chk("ALU_SEL", {28'd0, ALU_SEL}, {28'd0, w_he.alu});
        chk("pc_SEL", {30'd0, pc_SEL}, {30'd0, m_pc1, m_redir});
        chk("flush", {31'd0, flush}, {31'd0, m_redir});
        chk("mem_WE", {31'd0, mem_WE}, {31'd0, m_vm && w_m.mwe});
        chk("reg_SEL", {30'd0, reg_SEL}, {30'd0, w_hw.rsel});
        chk("reg_WE", {31'd0, reg_WE}, {31'd0, m_vw && w_w.rwe});
        chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
    end

    // ---------------- directed stimulus ----------------
    // {alu_eq, alu_lt, alu_ltu, Instr}; flags apply in the cycle the word is driven
    function automatic logic [34:0] stim(input int i);
        case (i)
            0:  return {3'b000, ADD};
            1:  return {3'b000, SUB};
            2:  return {3'b000, SRAI};
            5:  return {3'b000, SW};
            9:  return {3'b000, BEQ};
            10: return {3'b000, ADD};
            11: return {3'b100, SW};     // BEQ@9 sits in E here: taken
            12: return {3'b000, ADD};
            13: return {3'b000, ADD};
            15: return {3'b000, BEQ};
            16: return {3'b000, ADD};
            17: return {3'b011, NOP};    // BEQ@15 in E: eq=0, not taken
            18: return {3'b000, ADD};
            20: return {3'b000, JALR};
            21: return {3'b000, ADDI0};
            24: return {3'b000, ADDI0};
            28: return {3'b000, ILL};
            30: return {3'b000, SW};
            default: return {3'b000, NOP};
        endcase
    endfunction

    function automatic logic [31:0] all_outs();
        return {12'd0, imm_SEL, rs1_SEL, rs2_SEL, ALU_SEL, pc_SEL, mem_WE, reg_SEL, reg_WE, flush, illegal};
    endfunction

    // Cycle j: D holds entry j-1, E j-2, M j-3, WB j-4; a redirect from entry k shows at cycle k+3.
    task automatic hand(input int j);
        case (j)
            2:  begin chk("lit ADD alu", {28'd0, ALU_SEL}, 0); chk("lit ADD rs2", {31'd0, rs2_SEL}, 0); end
            3:  begin chk("lit SUB alu", {28'd0, ALU_SEL}, 1); chk("lit SUB rs2", {31'd0, rs2_SEL}, 0); end
            4:  begin chk("lit SRAI alu", {28'd0, ALU_SEL}, 7); chk("lit SRAI rs2", {31'd0, rs2_SEL}, 1);
                      chk("lit ADD wb we", {31'd0, reg_WE}, 1); chk("lit ADD wb sel", {30'd0, reg_SEL}, 1); end
            5:  chk("lit SUB wb we", {31'd0, reg_WE}, 1);
            6:  begin chk("lit SRAI wb we", {31'd0, reg_WE}, 1); chk("lit SW imm", {29'd0, imm_SEL}, 1); end
            8:  chk("lit SW mem_WE", {31'd0, mem_WE}, 1);
            9:  begin chk("lit SW mem_WE off", {31'd0, mem_WE}, 0); chk("lit SW no wb", {31'd0, reg_WE}, 0); end
            12: begin chk("lit BEQ pc_SEL", {30'd0, pc_SEL}, 3); chk("lit BEQ flush", {31'd0, flush}, 1); end
            13: begin chk("lit BEQ pc_SEL once", {30'd0, pc_SEL}, 0); chk("lit flush once", {31'd0, flush}, 0); end
            14: begin chk("lit squash SW", {31'd0, mem_WE}, 0); chk("lit squash ADD", {31'd0, reg_WE}, 0); end
            16: chk("lit squash ADD2", {31'd0, reg_WE}, 0);
            17: chk("lit post-redirect ADD", {31'd0, reg_WE}, 1);
            18: begin chk("lit BEQ nt pc_SEL", {30'd0, pc_SEL}, 0); chk("lit BEQ nt flush", {31'd0, flush}, 0); end
            20: chk("lit no bubble ADD", {31'd0, reg_WE}, 1);
            22: chk("lit no bubble ADD2", {31'd0, reg_WE}, 1);
            23: begin chk("lit JALR pc_SEL", {30'd0, pc_SEL}, 1); chk("lit JALR flush", {31'd0, flush}, 1); end
            24: begin chk("lit JALR link we", {31'd0, reg_WE}, 1); chk("lit JALR link sel", {30'd0, reg_SEL}, 3); end
            28: begin chk("lit ADDI x0 we", {31'd0, reg_WE}, 0); chk("lit ADDI x0 sel", {30'd0, reg_SEL}, 1); end
            29: chk("lit illegal before", {31'd0, illegal}, 0);
            30: chk("lit illegal set", {31'd0, illegal}, 1);
            31: chk("lit illegal sticky", {31'd0, illegal}, 1);
            32: chk("lit illegal bubble we", {31'd0, reg_WE}, 0);
            default: ;
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) begin
            @(negedge clk);
            chk("reset outputs", all_outs(), 0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post-reset outputs", all_outs(), 0);
        for (int j = 0; j < N; j++) begin
            @(posedge clk);
            #1 {alu_eq, alu_lt, alu_ltu, Instr} = stim(j);
            @(negedge clk);
            hand(j);
        end
        // store from entry 30 is in E now; reset must kill it before M
        #1 reset = 1'b1;
        Instr = NOP;
        {alu_eq, alu_lt, alu_ltu} = 3'b000;
        repeat (2) begin
            @(negedge clk);
            chk("mid reset outputs", all_outs(), 0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("after reset mem_WE", {31'd0, mem_WE}, 0);
            chk("after reset illegal", {31'd0, illegal}, 0);
            @(posedge clk);
            #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
